// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of the Decode/Execute hazard inputs and the pipeline-register
// control outputs exchanged with the hazard/stall controller.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_br_taken;
    logic             mem_busy;

    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_we;
    logic             id_ex_flush;
    logic             ex_mem_we;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_rd, ex_mem_read, ex_br_taken, mem_busy,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we,
        input  stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_rd, ex_mem_read, ex_br_taken, mem_busy,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we,
        output stall_count, flush_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline. Inserts load-use
// bubbles, flushes on a taken branch/jump resolved in Execute, freezes the
// pipe while data memory is busy, and keeps saturating stall/flush counters.
// Control outputs respond in the same cycle as the inputs.
module hazard_stall_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input logic                CLK,
    input logic                RST,
    hazard_stall_ctrl_if.slave hs
);
    typedef enum logic {RUN = 1'b0, LSTALL = 1'b1} state_t;

    // Remaining bubbles after the one issued in the hazard-detect cycle.
    localparam logic [2:0] RELOAD = 3'(LOAD_STALL_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard;
    logic             stall_evt;
    logic             flush_evt;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    // A load writing x0 never matters; only registers actually read count.
    assign hazard = hs.ex_mem_read && (hs.ex_rd != 5'd0) &&
                    ((hs.id_rs1_used && (hs.id_rs1 == hs.ex_rd)) ||
                     (hs.id_rs2_used && (hs.id_rs2 == hs.ex_rd)));

    // Next state and pipeline controls, priority busy > branch > LSTALL > hazard.
    always_comb begin
        hs.pc_we       = 1'b1;
        hs.if_id_we    = 1'b1;
        hs.if_id_flush = 1'b0;
        hs.id_ex_we    = 1'b1;
        hs.id_ex_flush = 1'b0;
        hs.ex_mem_we   = 1'b1;
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_evt      = 1'b0;
        flush_evt      = 1'b0;

        if (RST) begin
            hs.pc_we       = 1'b0;
            hs.if_id_we    = 1'b0;
            hs.id_ex_we    = 1'b0;
            hs.ex_mem_we   = 1'b0;
            hs.if_id_flush = 1'b1;
            hs.id_ex_flush = 1'b1;
            state_d        = RUN;
            cnt_d          = 3'd0;
        end else if (hs.mem_busy) begin
            hs.pc_we     = 1'b0;
            hs.if_id_we  = 1'b0;
            hs.id_ex_we  = 1'b0;
            hs.ex_mem_we = 1'b0;
            stall_evt    = 1'b1;
        end else if (hs.ex_br_taken) begin
            // The dependent instruction is squashed, so any pending load stall is moot.
            hs.if_id_flush = 1'b1;
            hs.id_ex_flush = 1'b1;
            state_d        = RUN;
            cnt_d          = 3'd0;
            flush_evt      = 1'b1;
        end else if (state_q == LSTALL) begin
            hs.pc_we       = 1'b0;
            hs.if_id_we    = 1'b0;
            hs.id_ex_flush = 1'b1;
            stall_evt      = 1'b1;
            cnt_d          = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                state_d = RUN;
            end
        end else if (hazard) begin
            hs.pc_we       = 1'b0;
            hs.if_id_we    = 1'b0;
            hs.id_ex_flush = 1'b1;
            stall_evt      = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = LSTALL;
                cnt_d   = RELOAD;
            end
        end

        stall_cnt_d = sat_inc(stall_cnt_q, stall_evt);
        flush_cnt_d = sat_inc(flush_cnt_q, flush_evt);
    end

    // State, bubble counter and performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hs.stall_count = stall_cnt_q;
    assign hs.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;
    logic        CLK  = 1'b0;
    logic        RST  = 1'b1;
    logic [19:0] stim = '0;

    always #5 CLK = ~CLK;

    // Control vectors {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we}
    localparam logic [5:0] NORMAL = 6'b110101;
    localparam logic [5:0] STALL  = 6'b000111;
    localparam logic [5:0] FLUSH  = 6'b111111;
    localparam logic [5:0] BUSY   = 6'b000000;
    localparam logic [5:0] RST_O  = 6'b001010;

    hazard_stall_ctrl_if #(.CNT_W(32)) if1 ();
    hazard_stall_ctrl_if #(.CNT_W(32)) if2 ();
    hazard_stall_ctrl_if #(.CNT_W(32)) if3 ();
    hazard_stall_ctrl_if #(.CNT_W(4))  ifs ();

    assign {if1.id_rs1, if1.id_rs2, if1.id_rs1_used, if1.id_rs2_used, if1.ex_rd,
            if1.ex_mem_read, if1.ex_br_taken, if1.mem_busy} = stim;
    assign {if2.id_rs1, if2.id_rs2, if2.id_rs1_used, if2.id_rs2_used, if2.ex_rd,
            if2.ex_mem_read, if2.ex_br_taken, if2.mem_busy} = stim;
    assign {if3.id_rs1, if3.id_rs2, if3.id_rs1_used, if3.id_rs2_used, if3.ex_rd,
            if3.ex_mem_read, if3.ex_br_taken, if3.mem_busy} = stim;
    assign {ifs.id_rs1, ifs.id_rs2, ifs.id_rs1_used, ifs.id_rs2_used, ifs.ex_rd,
            ifs.ex_mem_read, ifs.ex_br_taken, ifs.mem_busy} = stim;

    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut1 (.CLK(CLK), .RST(RST), .hs(if1));
    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(32)) dut2 (.CLK(CLK), .RST(RST), .hs(if2));
    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) dut3 (.CLK(CLK), .RST(RST), .hs(if3));
    hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(4))  duts (.CLK(CLK), .RST(RST), .hs(ifs));

    typedef struct {
        int         w;
        logic [5:0] exp;
        string      name;
    } sb_t;

    typedef struct {
        logic [19:0] in;
        logic [5:0]  exp;
        string       name;
    } vec_t;

    sb_t  sbq[$];
    vec_t tbl[12];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [19:0] mk(input int rs1, input int rs2, input bit u1, input bit u2,
                                       input int rd, input bit mr, input bit br, input bit busy);
        logic [4:0] a, b, d;
        a = 5'(rs1);
        b = 5'(rs2);
        d = 5'(rd);
        return {a, b, u1, u2, d, mr, br, busy};
    endfunction

    function automatic logic [5:0] outs(input int w);
        case (w)
            1: return {if1.pc_we, if1.if_id_we, if1.if_id_flush, if1.id_ex_we, if1.id_ex_flush, if1.ex_mem_we};
            2: return {if2.pc_we, if2.if_id_we, if2.if_id_flush, if2.id_ex_we, if2.id_ex_flush, if2.ex_mem_we};
            3: return {if3.pc_we, if3.if_id_we, if3.if_id_flush, if3.id_ex_we, if3.id_ex_flush, if3.ex_mem_we};
            default: return {ifs.pc_we, ifs.if_id_we, ifs.if_id_flush, ifs.id_ex_we, ifs.id_ex_flush, ifs.ex_mem_we};
        endcase
    endfunction

    function automatic logic [31:0] scnt(input int w);
        case (w)
            1: return if1.stall_count;
            2: return if2.stall_count;
            3: return if3.stall_count;
            default: return {28'd0, ifs.stall_count};
        endcase
    endfunction

    function automatic logic [31:0] fcnt(input int w);
        case (w)
            1: return if1.flush_count;
            2: return if2.flush_count;
            3: return if3.flush_count;
            default: return {28'd0, ifs.flush_count};
        endcase
    endfunction

    task automatic expect_o(input int w, input logic [5:0] e, input string n);
        sb_t s;
        s.w    = w;
        s.exp  = e;
        s.name = n;
        sbq.push_back(s);
    endtask

    // Outputs are compared on the falling edge, then we move to just past the next rising edge.
    task automatic cycle();
        sb_t        s;
        logic [5:0] a;
        @(negedge CLK);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            a = outs(s.w);
            checks++;
            if (a !== s.exp) begin
                failures++;
                $display("FAIL %s dut%0d ctrl=%b expected=%b", s.name, s.w, a, s.exp);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [19:0] v, input int w, input logic [5:0] e, input string n);
        stim = v;
        expect_o(w, e, n);
        cycle();
    endtask

    task automatic check_cnt(input int w, input logic [31:0] es, input logic [31:0] ef, input string n);
        checks++;
        if (scnt(w) !== es) begin
            failures++;
            $display("FAIL %s dut%0d stall_count=%0d expected=%0d", n, w, scnt(w), es);
        end
        checks++;
        if (fcnt(w) !== ef) begin
            failures++;
            $display("FAIL %s dut%0d flush_count=%0d expected=%0d", n, w, fcnt(w), ef);
        end
    endtask

    task automatic do_reset();
        RST  = 1'b1;
        stim = '0;
        repeat (2) begin
            for (int w = 1; w <= 4; w++) expect_o(w, RST_O, "reset_ctrl");
            cycle();
        end
        RST = 1'b0;
    endtask

    initial begin
        int exp_s;
        int exp_f;

        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0), NORMAL, "idle"};
        tbl[1]  = '{mk(5, 0, 1, 0, 5, 1, 0, 0), STALL,  "lu_rs1"};
        tbl[2]  = '{mk(5, 0, 1, 0, 5, 0, 0, 0), NORMAL, "after_lu"};
        tbl[3]  = '{mk(1, 9, 1, 1, 9, 1, 0, 0), STALL,  "lu_rs2"};
        tbl[4]  = '{mk(1, 5, 1, 0, 5, 1, 0, 0), NORMAL, "rs2_unused"};
        tbl[5]  = '{mk(0, 0, 1, 1, 0, 1, 0, 0), NORMAL, "rd_x0"};
        tbl[6]  = '{mk(5, 5, 1, 1, 5, 0, 0, 0), NORMAL, "not_load"};
        tbl[7]  = '{mk(3, 4, 1, 1, 7, 0, 1, 0), FLUSH,  "branch"};
        tbl[8]  = '{mk(7, 0, 1, 0, 7, 1, 1, 0), FLUSH,  "br_over_haz"};
        tbl[9]  = '{mk(7, 0, 1, 0, 7, 1, 0, 1), BUSY,   "busy_haz"};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 1, 1), BUSY,   "busy_br"};
        tbl[11] = '{mk(5, 6, 1, 1, 7, 1, 0, 0), NORMAL, "rd_mismatch"};

        @(posedge CLK);
        #1;

        // Reset behaviour and first normal cycle
        do_reset();
        for (int w = 1; w <= 4; w++) check_cnt(w, 0, 0, "reset_cnt");
        drive('0, 1, NORMAL, "post_reset");

        // Single-cycle vector table on the one-bubble controller
        exp_s = 0;
        exp_f = 0;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].in, 1, tbl[i].exp, tbl[i].name);
            if (tbl[i].exp[5] == 1'b0) exp_s++;
            if (tbl[i].exp == FLUSH) exp_f++;
        end
        check_cnt(1, 32'(exp_s), 32'(exp_f), "table_cnt");

        // Load-use with one bubble
        do_reset();
        drive(mk(5, 0, 1, 0, 5, 1, 0, 0), 1, STALL, "p1_stall");
        drive('0, 1, NORMAL, "p1_resume");
        check_cnt(1, 1, 0, "p1_cnt");

        // Load-use with three bubbles; hazard input drops after the first
        do_reset();
        drive(mk(5, 0, 1, 0, 5, 1, 0, 0), 3, STALL, "p3_stall1");
        drive('0, 3, STALL, "p3_stall2");
        drive('0, 3, STALL, "p3_stall3");
        drive('0, 3, NORMAL, "p3_resume");
        check_cnt(3, 3, 0, "p3_cnt");

        // Taken branch during the second bubble aborts the load stall
        do_reset();
        drive(mk(5, 0, 1, 0, 5, 1, 0, 0), 3, STALL, "br_ls_stall");
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0), 3, FLUSH, "br_ls_flush");
        drive('0, 3, NORMAL, "br_ls_resume");
        check_cnt(3, 1, 1, "br_ls_cnt");

        // Memory busy freezes an LSTALL with two bubbles; branch ignored while busy
        do_reset();
        drive(mk(5, 0, 1, 0, 5, 1, 0, 0), 2, STALL, "busy_ls_stall");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1), 2, BUSY, "busy_ls_1");
        drive(mk(0, 0, 0, 0, 0, 0, 1, 1), 2, BUSY, "busy_ls_br");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1), 2, BUSY, "busy_ls_3");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1), 2, BUSY, "busy_ls_4");
        drive('0, 2, STALL, "busy_ls_resume");
        drive('0, 2, NORMAL, "busy_ls_run");
        check_cnt(2, 6, 0, "busy_ls_cnt");

        // Four-bit counter saturates at 15
        do_reset();
        repeat (20) drive(mk(0, 0, 0, 0, 0, 0, 0, 1), 4, BUSY, "sat_busy");
        check_cnt(4, 15, 0, "sat_cnt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
